// File: rtl/rs_pkg.sv
// rtl/rs_pkg.sv - shared sizes, slot vector types and helpers for the reservation-station issue scheduler
package rs_pkg;

  localparam int RS_NUM_SLOTS  = 8;
  localparam int RS_SLOT_IDX_W = $clog2(RS_NUM_SLOTS);

  typedef logic [RS_NUM_SLOTS-1:0]  rs_slot_vec_t;
  typedef logic [RS_SLOT_IDX_W-1:0] rs_slot_idx_t;

  function automatic rs_slot_idx_t onehot_to_idx(input rs_slot_vec_t oh);
    rs_slot_idx_t idx;
    idx = '0;
    for (int i = 0; i < RS_NUM_SLOTS; i++) begin
      if (oh[i]) idx = rs_slot_idx_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rs_age_matrix.sv
// rtl/rs_age_matrix.sv - slot age matrix (age[i][j]=1: slot i older than j) with oldest-of-mask select
module rs_age_matrix
  import rs_pkg::*;
#(
  parameter int NUM_SLOTS = RS_NUM_SLOTS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic [NUM_SLOTS-1:0] slot_busy,
  input  logic [NUM_SLOTS-1:0] slot_wr,
  input  logic [NUM_SLOTS-1:0] mask,
  output logic [NUM_SLOTS-1:0] oldest
);

  logic [NUM_SLOTS-1:0] age [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] no_older;
  logic [NUM_SLOTS-1:0] older_seen;
  logic                 found;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SLOTS; i++) age[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < NUM_SLOTS; i++) age[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        for (int j = 0; j < NUM_SLOTS; j++) begin
          if (i == j)                         age[i][j] <= 1'b0;
          else if (slot_wr[i])                age[i][j] <= 1'b0;
          else if (slot_wr[j] && slot_busy[i]) age[i][j] <= 1'b1;
        end
      end
    end
  end

  // Stale entries of freed slots can leave ties; lowest index breaks them.
  always_comb begin
    older_seen = '0;
    no_older   = '0;
    oldest     = '0;
    found      = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      for (int j = 0; j < NUM_SLOTS; j++) begin
        if (mask[j] && age[j][i]) older_seen[i] = 1'b1;
      end
      no_older[i] = mask[i] & ~older_seen[i];
    end
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (no_older[i] && !found) begin
        oldest[i] = 1'b1;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rs_issue_sched.sv
// rtl/rs_issue_sched.sv - oldest-ready-first issue scheduler; RS_ISSUE_PERF_EN adds issue/stall counters
module rs_issue_sched
  import rs_pkg::*;
#(
  parameter int NUM_SLOTS  = RS_NUM_SLOTS,
  parameter int SLOT_IDX_W = $clog2(NUM_SLOTS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_SLOTS-1:0]  rs_slot_busy,
  input  logic [NUM_SLOTS-1:0]  rs_slot_ready,
  input  logic [NUM_SLOTS-1:0]  rs_slot_wr,
  input  logic                  flush,
  input  logic                  fu_ready,
  output logic                  issue_valid,
  output logic [SLOT_IDX_W-1:0] issue_idx,
  output logic [NUM_SLOTS-1:0]  issue_onehot,
`ifdef RS_ISSUE_PERF_EN
  output logic [NUM_SLOTS-1:0]  slot_free,
  output logic [31:0]           perf_issue_cnt,
  output logic [31:0]           perf_stall_cnt
`else
  output logic [NUM_SLOTS-1:0]  slot_free
`endif
);

  logic [NUM_SLOTS-1:0]  cand;
  logic [NUM_SLOTS-1:0]  winner;
  logic [SLOT_IDX_W-1:0] winner_idx;
  logic                  handshake;
  logic                  load;

  // issue_onehot is zero when idle, so this drops the held or departing slot.
  assign cand      = rs_slot_busy & rs_slot_ready & ~issue_onehot;
  assign handshake = issue_valid & fu_ready;
  assign load      = ~issue_valid | fu_ready;
  assign slot_free = issue_onehot & {NUM_SLOTS{handshake & ~flush}};

  rs_age_matrix #(.NUM_SLOTS(NUM_SLOTS)) u_age (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .slot_busy (rs_slot_busy),
    .slot_wr   (rs_slot_wr),
    .mask      (cand),
    .oldest    (winner)
  );

  always_comb begin
    winner_idx = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (winner[i]) winner_idx = SLOT_IDX_W'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_valid  <= 1'b0;
      issue_idx    <= '0;
      issue_onehot <= '0;
    end else if (flush) begin
      issue_valid  <= 1'b0;
      issue_idx    <= '0;
      issue_onehot <= '0;
    end else if (load) begin
      issue_valid  <= |winner;
      issue_idx    <= winner_idx;
      issue_onehot <= winner;
    end
  end

`ifdef RS_ISSUE_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_issue_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (handshake && !(&perf_issue_cnt)) perf_issue_cnt <= perf_issue_cnt + 32'd1;
      if (issue_valid && !fu_ready && !(&perf_stall_cnt)) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

  a_no_wr_on_issued: assert property (@(posedge clk) disable iff (!rst_n)
    !(issue_valid && !flush && |(rs_slot_wr & issue_onehot)))
    else $error("rs_issue_sched: allocation into slot %0d while it is being issued", issue_idx);

  a_held_stays_ready: assert property (@(posedge clk) disable iff (!rst_n)
    !(issue_valid && !flush && |(issue_onehot & ~rs_slot_ready)))
    else $warning("rs_issue_sched: issued slot %0d lost ready without replay", issue_idx);

endmodule

// File: doc/rs_issue_sched.md
Name: rs_issue_sched

Overview:
- Oldest-ready-first issue scheduler for the reservation station.
- Each cycle it picks one busy slot with all operands ready and presents it to the functional unit (FU) over a valid/ready handshake.
- On handshake it pulses that slot's free line so the RS clears the slot's busy bit.
- Age order comes from an age matrix updated by the RS slot write enables.

Parameters:
- NUM_SLOTS, 8, number of RS slots; must be ≥2.
- SLOT_IDX_W, $clog2(NUM_SLOTS), width of the slot index.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, active-low.
- rs_slot_busy  in  NUM_SLOTS  slot holds a valid instruction.
- rs_slot_ready  in  NUM_SLOTS  slot's operands are all ready; ignored where busy=0.
- rs_slot_wr  in  NUM_SLOTS  one-hot-or-zero slot write enable (allocation this cycle).
- flush  in  1  synchronous pipeline flush.
- fu_ready  in  1  FU accepts an issue this cycle.
- issue_valid  out  1  issue_idx holds a valid slot.
- issue_idx  out  SLOT_IDX_W  slot being issued.
- issue_onehot  out  NUM_SLOTS  one-hot form of issue_idx; all zero when issue_valid=0.
- slot_free  out  NUM_SLOTS  one-cycle pulse clearing the issued slot.

Interface decision (fixed):
- One clock; reset is asynchronous and active-low.

Behaviour:
- Reset (rst_n=0, async):
  - issue_valid=0, issue_idx=0, issue_onehot=0, slot_free=0.
  - Age matrix all 0.
  - Perf counters 0.
- Age matrix: age[i][j]=1 means slot i is older than slot j.
  - On rs_slot_wr[k]: row k is cleared, and age[j][k]=1 is set for every j≠k with rs_slot_busy[j]=1. Takes effect at the next edge.
  - The diagonal is always 0.
- Candidate set: cand[i] = busy[i] & ready[i] & ~held[i].
  - held is the slot currently in the output register while issue_valid=1 and no handshake is occurring.
  - On a handshake cycle the departing slot is also excluded.
- Winner: the cand[i] for which no cand[j] has age[j][i]=1.
  - Exactly one winner while cand≠0.
  - Selection is combinational from cycle-t state and registered at the edge ending cycle t. Issue latency is 1 cycle from ready to issue_valid.
- Output register:
  - Loads the winner when issue_valid=0, or when issue_valid&fu_ready (back-to-back issue allowed, one per cycle).
  - If the load happens and cand=0, issue_valid goes to 0.
  - While issue_valid=1 and fu_ready=0, issue_idx and issue_onehot hold stable. A stall never changes the selection, even if an older slot becomes ready.
- slot_free = issue_onehot & {NUM_SLOTS{issue_valid & fu_ready & ~flush}}.
  - Combinational, in the same cycle as the handshake.
- flush:
  - At the next edge: issue_valid←0 and age matrix←0.
  - slot_free is suppressed in the flush cycle; the RS clears its own slots on flush.
  - rs_slot_wr is ignored in the flush cycle.
- Boundary conditions:
  - rs_slot_wr[k] while issue_onehot[k]=1 and issue_valid=1: illegal; asserted in simulation.
  - All slots busy and none ready: issue_valid stays 0.
  - Single busy ready slot: issued and freed, no re-issue.
  - A held slot whose ready drops (no replay in this design): still issued; asserted as a warning.
  - Reset asserted mid-stall: outputs clear immediately, with no slot_free pulse.

Optional Feature:
- Macro: RS_ISSUE_PERF_EN.
- When defined, two extra outputs are added:
  - perf_issue_cnt (32 b): increments on each handshake.
  - perf_stall_cnt (32 b): increments each cycle with issue_valid&~fu_ready.
  - Both saturate at all-ones, clear on reset, and are unaffected by flush.
- When undefined, these ports and registers do not exist and behaviour is otherwise identical.

Decomposition:
- Package rs_pkg holds:
  - localparam RS_NUM_SLOTS=8 and RS_SLOT_IDX_W.
  - typedef rs_slot_vec_t (logic [RS_NUM_SLOTS-1:0]).
  - typedef rs_slot_idx_t.
  - function onehot_to_idx.
- Sub-module rs_age_matrix:
  - Owns the NUM_SLOTS×NUM_SLOTS age register with alloc/flush update.
  - Outputs the oldest-of(mask) one-hot vector.
- rs_issue_sched instantiates rs_age_matrix and holds the output register and handshake logic.

Test Plan (NUM_SLOTS=8):
- Reset with busy=8'hFF, ready=8'hFF: issue_valid=0, slot_free=0 until rst_n rises; first issue one cycle after.
- Allocate slots 3, 1, 6 in consecutive cycles, then set ready=8'h4A together: issues in order 3, 1, 6 on consecutive cycles with fu_ready=1; slot_free=8'h08, 8'h02, 8'h40.
- Slot 5 issued with fu_ready=0 for 4 cycles while older slot 2 becomes ready: issue_idx holds 5 for all 4 cycles. After fu_ready=1: slot_free=8'h20, then issue_idx=2 the next cycle.
- Allocate slot 0 after slot 7, both ready, fu_ready=1: 7 issues before 0 (age order, not index order).
- flush asserted while issue_valid=1 and fu_ready=1: slot_free=0 that cycle and issue_valid=0 the next; after re-allocating slots 4 then 2, order is 4, 2.
- With RS_ISSUE_PERF_EN: 3 handshakes plus 5 stall cycles give perf_issue_cnt=3 and perf_stall_cnt=5; after flush, counts are unchanged.
